// File: rtl/cnv_pkg.sv
// cnv_pkg: shared defaults, FSM encoding and width helper for the row convolution engine
package cnv_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int DATA_W_D = 8;
  localparam int PSUM_W_D = 24;
  localparam int BLOCK_DEPTH_D = 32;
  localparam int LANE_W = 2 * DATA_W_D + clog2(BLOCK_DEPTH_D);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
endpackage

// File: rtl/cnv_row_gen_if.sv
// cnv_row_gen_if: valid/ready drain port carrying completed row psums
interface cnv_row_gen_if #(
  parameter int PSUM_W = 24
);
  logic out_vld;
  logic out_rdy;
  logic out_last;
  logic [PSUM_W-1:0] out_psum;
  modport master(output out_vld, out_psum, out_last, input out_rdy);
  modport slave(input out_vld, out_psum, out_last, output out_rdy);
endinterface

// File: rtl/cnv_mac_lane.sv
// cnv_mac_lane: one sequential flag-gated signed MAC lane stepping through a block by index
module cnv_mac_lane import cnv_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int BLOCK_DEPTH = BLOCK_DEPTH_D,
  parameter int LW = 2 * DATA_W + clog2(BLOCK_DEPTH),
  localparam int IW = clog2(BLOCK_DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic [IW-1:0] idx,
  input  logic [BLOCK_DEPTH-1:0] flg_a,
  input  logic [BLOCK_DEPTH-1:0] flg_w,
  input  logic [DATA_W*BLOCK_DEPTH-1:0] act,
  input  logic [DATA_W*BLOCK_DEPTH-1:0] wei,
  output logic signed [LW-1:0] sum
);
  logic signed [DATA_W-1:0] a, w;
  logic signed [2*DATA_W-1:0] p;
  assign a = act[idx*DATA_W +: DATA_W];
  assign w = wei[idx*DATA_W +: DATA_W];
  assign p = a * w;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (clr) sum <= '0;
    else if (en && flg_a[idx] && flg_w[idx]) sum <= sum + LW'(p);
endmodule

// File: rtl/cnv_row_gen.sv
// cnv_row_gen: KSIZE-lane sparse row convolution, run-time-length row buffer and ordered drain
// PSUM_SAT_EN: when defined, accumulation saturates and flags err instead of wrapping
module cnv_row_gen import cnv_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int BLOCK_DEPTH = BLOCK_DEPTH_D,
  parameter int KSIZE = 3,
  parameter int LENROW_MAX = 16,
  parameter int PSUM_W = PSUM_W_D,
  localparam int CW = clog2(LENROW_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [CW-1:0] cfg_lenrow,
  input  logic sta,
  input  logic [BLOCK_DEPTH-1:0] flg_act,
  input  logic [DATA_W*BLOCK_DEPTH-1:0] act,
  input  logic [KSIZE*BLOCK_DEPTH-1:0] flg_wei,
  input  logic [KSIZE*DATA_W*BLOCK_DEPTH-1:0] wei,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic acc_pls,
  input  logic row_fnh,
  output logic busy,
  output logic mac_fnh,
  cnv_row_gen_if.master dn,
  output logic err
);
  localparam int IW = clog2(BLOCK_DEPTH);
  localparam int AW = clog2(LENROW_MAX);
  localparam int LW = 2 * DATA_W + IW;
  localparam int SUM_W = LW + clog2(KSIZE);
  localparam logic [IW:0] DONE = (IW + 1)'(BLOCK_DEPTH);
  logic [1:0] state;
  logic [IW:0] idx;
  logic [BLOCK_DEPTH-1:0] fa_r;
  logic [KSIZE*BLOCK_DEPTH-1:0] fw_r;
  logic [DATA_W*BLOCK_DEPTH-1:0] act_r;
  logic [KSIZE*DATA_W*BLOCK_DEPTH-1:0] wei_r;
  logic signed [LW-1:0] lane_sum [KSIZE];
  logic signed [SUM_W-1:0] tot;
  logic signed [PSUM_W-1:0] held;
  logic [PSUM_W-1:0] row_buf [LENROW_MAX];
  logic [PSUM_W-1:0] acc;
  logic [CW-1:0] cnt, cnt_n, len_r, rd, cfg_len;
  logic idle, mac, hold, drn, go, acc_do, fin_ok, xfer, last, sat, bad;
  genvar g;
  for (g = 0; g < KSIZE; g++) begin : g_lane
    cnv_mac_lane #(.DATA_W(DATA_W), .BLOCK_DEPTH(BLOCK_DEPTH), .LW(LW)) u_lane (
      .clk(clk), .rst_n(rst_n), .clr(go), .en(mac & ~idx[IW]), .idx(idx[IW-1:0]),
      .flg_a(fa_r), .flg_w(fw_r[g*BLOCK_DEPTH +: BLOCK_DEPTH]),
      .act(act_r), .wei(wei_r[g*DATA_W*BLOCK_DEPTH +: DATA_W*BLOCK_DEPTH]), .sum(lane_sum[g])
    );
  end
  always_comb begin
    tot = '0;
    for (int k = 0; k < KSIZE; k++) tot = tot + SUM_W'(lane_sum[k]);
  end
`ifdef PSUM_SAT_EN
  logic [PSUM_W:0] sum_x;
  assign sum_x = {held[PSUM_W-1], held} + {psum_in[PSUM_W-1], psum_in};
  assign sat = sum_x[PSUM_W] ^ sum_x[PSUM_W-1];
  assign acc = sat ? {sum_x[PSUM_W], {(PSUM_W - 1){~sum_x[PSUM_W]}}} : sum_x[PSUM_W-1:0];
`else
  assign sat = 1'b0;
  assign acc = held + psum_in;
`endif
  assign idle = state == S_IDLE;
  assign mac = state == S_MAC;
  assign hold = state == S_HOLD;
  assign drn = state == S_DRAIN;
  assign go = sta & (idle | hold);
  assign acc_do = acc_pls & hold & (cnt != len_r);
  assign cnt_n = cnt + CW'(acc_do);
  assign fin_ok = row_fnh & (idle | hold);
  assign xfer = drn & dn.out_rdy;
  assign last = drn && rd == cnt - 1'b1;
  assign cfg_len = (cfg_lenrow == '0 || cfg_lenrow > CW'(LENROW_MAX)) ? CW'(LENROW_MAX) : cfg_lenrow;
  // a full row, a premature accumulate and any command outside its legal states all latch err
  assign bad = ((acc_pls | sta | row_fnh) & (mac | drn)) | (acc_pls & idle) | (acc_pls & hold & ~acc_do) | (acc_do & sat);
  assign busy = mac | drn;
  assign dn.out_vld = drn;
  assign dn.out_last = last;
  assign dn.out_psum = drn ? row_buf[rd[AW-1:0]] : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      fa_r <= '0;
      fw_r <= '0;
      act_r <= '0;
      wei_r <= '0;
      held <= '0;
      cnt <= '0;
      rd <= '0;
      len_r <= CW'(LENROW_MAX);
      err <= 1'b0;
      mac_fnh <= 1'b0;
      for (int j = 0; j < LENROW_MAX; j++) row_buf[j] <= '0;
    end else begin
      mac_fnh <= 1'b0;
      cnt <= cnt_n;
      if (bad) err <= 1'b1;
      if (acc_do) row_buf[cnt[AW-1:0]] <= acc;
      if (fin_ok) len_r <= cfg_len;
      if (mac) idx <= idx + 1'b1;
      if (go) begin
        act_r <= act;
        wei_r <= wei;
        fa_r <= flg_act;
        fw_r <= flg_wei;
        idx <= '0;
      end
      // the extra cycle at idx==DONE lets the final lane adds settle before the result is held
      if (fin_ok && cnt_n != '0) begin
        state <= S_DRAIN;
        rd <= '0;
      end else if (go) state <= S_MAC;
      else if (mac && idx == DONE) begin
        state <= S_HOLD;
        held <= PSUM_W'(tot);
        mac_fnh <= 1'b1;
      end else if (xfer && last) begin
        state <= S_IDLE;
        cnt <= '0;
        rd <= '0;
        for (int j = 0; j < LENROW_MAX; j++) row_buf[j] <= '0;
      end else if (xfer) rd <= rd + 1'b1;
    end
endmodule

// File: tb/tb_cnv_row_gen.sv
// tb_cnv_row_gen: directed self-checking bench for cnv_row_gen with hand-computed expectations
module tb_cnv_row_gen;
  localparam int DW = 8, BD = 32, K = 3, PW = 24, LM = 16;
  logic clk = 1'b0, rst_n = 1'b0, sta = 1'b0, acc_pls = 1'b0, row_fnh = 1'b0;
  logic [4:0] cfg_lenrow = '0;
  logic [BD-1:0] flg_act = '0;
  logic [DW*BD-1:0] act = '0;
  logic [K*BD-1:0] flg_wei = '0;
  logic [K*DW*BD-1:0] wei = '0;
  logic [PW-1:0] psum_in = '0;
  logic busy, mac_fnh, err;
  logic [PW-1:0] exp_q [LM];
  int n_cmp = 0, n_err = 0;
  cnv_row_gen_if #(.PSUM_W(PW)) dn ();
  cnv_row_gen #(.DATA_W(DW), .BLOCK_DEPTH(BD), .KSIZE(K), .LENROW_MAX(LM), .PSUM_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_lenrow(cfg_lenrow), .sta(sta), .flg_act(flg_act), .act(act),
    .flg_wei(flg_wei), .wei(wei), .psum_in(psum_in), .acc_pls(acc_pls), .row_fnh(row_fnh),
    .busy(busy), .mac_fnh(mac_fnh), .dn(dn), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_mac(input logic [DW-1:0] av, input logic [DW-1:0] wv, input logic [BD-1:0] fa,
                         input logic [BD-1:0] f0, input logic [BD-1:0] f1, input logic [BD-1:0] f2, input bit poke);
    int n;
    n = 0;
    for (int i = 0; i < BD; i++) act[i*DW +: DW] = av;
    for (int i = 0; i < K * BD; i++) wei[i*DW +: DW] = wv;
    flg_act = fa;
    flg_wei = {f2, f1, f0};
    sta = 1'b1;
    tick;
    chk("mac_busy", busy, 1);
    do begin
      sta = poke && n == 5;
      tick;
      n++;
    end while (!mac_fnh && n < 100);
    sta = 1'b0;
    chk("mac_lat", n, 33);
    chk("mac_idle", busy, 0);
  endtask
  task automatic do_acc(input logic [PW-1:0] p);
    psum_in = p;
    acc_pls = 1'b1;
    tick;
    acc_pls = 1'b0;
  endtask
  task automatic fnh;
    row_fnh = 1'b1;
    tick;
    row_fnh = 1'b0;
  endtask
  task automatic drain(input int n, input bit tog);
    int got, cyc;
    bit r;
    got = 0;
    cyc = 0;
    r = 1'b1;
    while (got < n && cyc < 64) begin
      chk("drn_vld", dn.out_vld, 1);
      if (!dn.out_vld) break;
      chk("drn_psum", dn.out_psum, exp_q[got]);
      chk("drn_last", dn.out_last, got == n - 1);
      dn.out_rdy = r;
      tick;
      cyc++;
      if (r) got++;
      else chk("drn_stall", dn.out_psum, exp_q[got]);
      if (tog) r = ~r;
    end
    dn.out_rdy = 1'b0;
    chk("drn_cnt", got, n);
    chk("drn_end", dn.out_vld, 0);
  endtask
  task automatic do_rst;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask
  initial begin
    dn.out_rdy = 1'b0;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_fnh", mac_fnh, 0);
    chk("rst_vld", dn.out_vld, 0);
    chk("rst_last", dn.out_last, 0);
    chk("rst_psum", dn.out_psum, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick;
    run_mac(8'd1, 8'd2, '1, '1, '1, '1, 0);
    do_acc(24'd8);
    fnh;
    exp_q[0] = 24'd200;
    drain(1, 0);
    chk("dense_err", err, 0);
    run_mac(8'hFD, 8'd4, 32'h0000_000F, 32'h0000_0003, '0, '0, 0);
    do_acc(24'd0);
    fnh;
    exp_q[0] = 24'hFFFFE8;
    drain(1, 0);
    cfg_lenrow = 5'd4;
    fnh;
    chk("empty_fnh", dn.out_vld, 0);
    run_mac(8'd0, 8'd0, '0, '0, '0, '0, 0);
    for (int i = 1; i <= 4; i++) begin
      do_acc(PW'(i));
      exp_q[i-1] = PW'(i);
    end
    fnh;
    drain(4, 1);
    fnh;
    chk("row_cleared", dn.out_vld, 0);
    chk("row_err", err, 0);
    run_mac(8'd1, 8'd2, '1, '1, '1, '1, 0);
    do_acc(24'h7FFFFF);
`ifdef PSUM_SAT_EN
    exp_q[0] = 24'h7FFFFF;
    chk("sat_err", err, 1);
`else
    exp_q[0] = 24'h8000BF;
    chk("wrap_err", err, 0);
`endif
    fnh;
    drain(1, 0);
    do_rst;
    cfg_lenrow = 5'd2;
    fnh;
    run_mac(8'd0, 8'd0, '0, '0, '0, '0, 0);
    do_acc(24'd10);
    do_acc(24'd20);
    chk("ovf_pre_err", err, 0);
    do_acc(24'd30);
    chk("ovf_err", err, 1);
    fnh;
    exp_q[0] = 24'd10;
    exp_q[1] = 24'd20;
    drain(2, 0);
    do_rst;
    chk("rst_err_clr", err, 0);
    run_mac(8'd0, 8'd0, '0, '0, '0, '0, 1);
    chk("sta_mac_err", err, 1);
    do_rst;
    run_mac(8'd0, 8'd0, '0, '0, '0, '0, 0);
    do_acc(24'd5);
    do_acc(24'd6);
    fnh;
    chk("drn_on", dn.out_vld, 1);
    chk("drn_first", dn.out_psum, 5);
    chk("drn_err0", err, 0);
    do_acc(24'd99);
    chk("acc_drn_err", err, 1);
    chk("acc_drn_psum", dn.out_psum, 5);
    chk("acc_drn_vld", dn.out_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", dn.out_vld, 0);
    chk("arst_busy", busy, 0);
    chk("arst_psum", dn.out_psum, 0);
    chk("arst_err", err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
